// File: rtl/stickman_pkg.sv
// Shared constants and types for the layered colour mapper.
// Status encoding is one-hot {waiting, playing, win, lose}.
package stickman_pkg;

  localparam logic [3:0] ST_WAITING = 4'b1000;
  localparam logic [3:0] ST_PLAYING = 4'b0100;
  localparam logic [3:0] ST_WIN     = 4'b0010;
  localparam logic [3:0] ST_LOSE    = 4'b0001;

  // 8-bit reference colours, narrowed to COLOR_W by keeping the top bits
  localparam logic [23:0] BG_WAITING = 24'h000080;
  localparam logic [23:0] BG_WIN     = 24'h800000;
  localparam logic [23:0] BG_LOSE    = 24'h008000;
  localparam logic [7:0]  GRAD_RG    = 8'h4F;
  localparam logic [7:0]  GRAD_B_MAX = 8'h7F;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_OUT = 2'd1,
    FADE_IN  = 2'd2
  } fade_state_t;

endpackage

// File: rtl/layered_color_mapper_fade_ctrl.sv
// Frame counter and fade sequencer: owns displayed status, fade level and blink phase.
// All state moves only on frame_start so every value is stable for a whole frame.
module fade_ctrl
  import stickman_pkg::*;
#(
  parameter int FADE_LOG2  = 4,
  parameter int BLINK_LOG2 = 4
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 frame_start,
  input  logic [3:0]           status,
  output logic [3:0]           disp_status,
  output logic [FADE_LOG2:0]   level,
  output logic                 blink_off
);

  localparam int CNT_W = BLINK_LOG2 + 1;
  localparam logic [FADE_LOG2:0] LVL_FULL = {1'b1, {FADE_LOG2{1'b0}}};
  localparam logic [FADE_LOG2:0] LVL_ZERO = {(FADE_LOG2 + 1){1'b0}};
  localparam logic [FADE_LOG2:0] LVL_ONE  = {{FADE_LOG2{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W - 1){1'b0}}, 1'b1};

  fade_state_t          state_q, state_d;
  logic [FADE_LOG2:0]   level_q, level_d;
  logic [3:0]           disp_q, disp_d;
  logic [3:0]           target_q, target_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    disp_d   = disp_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    if (frame_start) begin
      cnt_d = cnt_q + CNT_ONE;
      case (state_q)
        IDLE: begin
          if (status != disp_q) begin
            target_d = status;
            state_d  = FADE_OUT;
          end else begin
            state_d = IDLE;
          end
        end
        FADE_OUT: begin
          if (status == disp_q) begin
            state_d = FADE_IN;
          end else begin
            target_d = status;
            // Reaching black is the only point where the displayed status may swap
            if (level_q <= LVL_ONE) begin
              level_d = LVL_ZERO;
              disp_d  = target_d;
              state_d = FADE_IN;
            end else begin
              level_d = level_q - LVL_ONE;
            end
          end
        end
        FADE_IN: begin
          if (status != disp_q) begin
            target_d = status;
            state_d  = FADE_OUT;
          end else if (level_q >= LVL_FULL - LVL_ONE) begin
            level_d = LVL_FULL;
            state_d = IDLE;
          end else begin
            level_d = level_q + LVL_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      level_q  <= LVL_FULL;
      disp_q   <= ST_WAITING;
      target_q <= ST_WAITING;
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      disp_q   <= disp_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

  assign disp_status = disp_q;
  assign level       = level_q;
  assign blink_off   = cnt_q[BLINK_LOG2];

endmodule

// File: rtl/layered_color_mapper.sv
// Two-stage pixel colour pipeline: layer/background selection, then per-channel fade scaling.
// Output is blanked whenever the aligned blank_n is low.
module layered_color_mapper
  import stickman_pkg::*;
#(
  parameter int N_LAYERS   = 4,
  parameter int COLOR_W    = 8,
  parameter int FADE_LOG2  = 4,
  parameter int BLINK_LOG2 = 4,
  parameter int GRAD_SHIFT = 3
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          frame_start,
  input  logic [3:0]                    status,
  input  logic [N_LAYERS-1:0]           layer_hit,
  input  logic [N_LAYERS*3*COLOR_W-1:0] layer_rgb,
  input  logic [N_LAYERS-1:0]           blink_mask,
  input  logic [9:0]                    DrawX,
  input  logic [9:0]                    DrawY,
  input  logic                          blank_n,
  output logic [COLOR_W-1:0]            VGA_R,
  output logic [COLOR_W-1:0]            VGA_G,
  output logic [COLOR_W-1:0]            VGA_B,
  output logic                          blank_n_out
);

  localparam int PIX_W = 3 * COLOR_W;

  function automatic logic [COLOR_W-1:0] top_bits(input logic [7:0] v);
    return v[7 -: COLOR_W];
  endfunction

  function automatic logic [PIX_W-1:0] bg_pix(input logic [23:0] c);
    return {top_bits(c[23:16]), top_bits(c[15:8]), top_bits(c[7:0])};
  endfunction

  function automatic logic [COLOR_W-1:0] scale(input logic [COLOR_W-1:0] c,
                                               input logic [FADE_LOG2:0] lvl);
    logic [COLOR_W+FADE_LOG2-1:0] prod;
    prod = {{FADE_LOG2{1'b0}}, c} * {{(COLOR_W - 1){1'b0}}, lvl};
    return COLOR_W'(prod >> FADE_LOG2);
  endfunction

  logic [3:0]          disp_status_s;
  logic [FADE_LOG2:0]  level_s;
  logic                blink_off_s;
  logic                unused_drawy;
  logic [9:0]          grad_x_s;
  logic [7:0]          grad_b_s;

  logic [PIX_W-1:0]    pix_q, pix_d;
  logic                blank1_q, blank1_d;
  logic [FADE_LOG2:0]  lvl1_q, lvl1_d;
  logic [COLOR_W-1:0]  vga_r_q, vga_r_d, vga_g_q, vga_g_d, vga_b_q, vga_b_d;
  logic                blank2_q, blank2_d;

  fade_ctrl #(
    .FADE_LOG2  (FADE_LOG2),
    .BLINK_LOG2 (BLINK_LOG2)
  ) u_fade_ctrl (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_start (frame_start),
    .status      (status),
    .disp_status (disp_status_s),
    .level       (level_s),
    .blink_off   (blink_off_s)
  );

  assign unused_drawy = ^DrawY;

  always_comb begin
    grad_x_s = DrawX >> GRAD_SHIFT;
    if (grad_x_s >= 10'h07F) begin
      grad_b_s = 8'h00;
    end else begin
      grad_b_s = GRAD_B_MAX - grad_x_s[7:0];
    end
  end

  // Descending scan so the lowest visible layer index is the last to write
  always_comb begin
    pix_d = {PIX_W{1'b0}};
    case (disp_status_s)
      ST_PLAYING: begin
        pix_d = {top_bits(GRAD_RG), top_bits(GRAD_RG), top_bits(grad_b_s)};
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
          if (layer_hit[i] && !(blink_mask[i] && blink_off_s)) begin
            pix_d = layer_rgb[i*PIX_W +: PIX_W];
          end else begin
            pix_d = pix_d;
          end
        end
      end
      ST_WAITING: pix_d = bg_pix(BG_WAITING);
      ST_WIN:     pix_d = bg_pix(BG_WIN);
      ST_LOSE:    pix_d = bg_pix(BG_LOSE);
      default:    pix_d = {PIX_W{1'b0}};
    endcase
    blank1_d = blank_n;
    lvl1_d   = level_s;
  end

  // Level travels with the pixel so a frame edge between stages cannot mix values
  always_comb begin
    if (blank1_q) begin
      vga_r_d = scale(pix_q[3*COLOR_W-1 -: COLOR_W], lvl1_q);
      vga_g_d = scale(pix_q[2*COLOR_W-1 -: COLOR_W], lvl1_q);
      vga_b_d = scale(pix_q[COLOR_W-1:0], lvl1_q);
    end else begin
      vga_r_d = {COLOR_W{1'b0}};
      vga_g_d = {COLOR_W{1'b0}};
      vga_b_d = {COLOR_W{1'b0}};
    end
    blank2_d = blank1_q;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      pix_q    <= {PIX_W{1'b0}};
      blank1_q <= 1'b0;
      lvl1_q   <= {(FADE_LOG2 + 1){1'b0}};
      vga_r_q  <= {COLOR_W{1'b0}};
      vga_g_q  <= {COLOR_W{1'b0}};
      vga_b_q  <= {COLOR_W{1'b0}};
      blank2_q <= 1'b0;
    end else begin
      pix_q    <= pix_d;
      blank1_q <= blank1_d;
      lvl1_q   <= lvl1_d;
      vga_r_q  <= vga_r_d;
      vga_g_q  <= vga_g_d;
      vga_b_q  <= vga_b_d;
      blank2_q <= blank2_d;
    end
  end

  assign VGA_R       = vga_r_q;
  assign VGA_G       = vga_g_q;
  assign VGA_B       = vga_b_q;
  assign blank_n_out = blank2_q;

endmodule

// File: tb/tb_layered_color_mapper.sv
// Scoreboard bench for layered_color_mapper: directed pixels push hand-computed colours,
// a negedge monitor pops and compares them two cycles after issue.
module tb_layered_color_mapper;
  import stickman_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        frame_start;
  logic [3:0]  status;
  logic [3:0]  layer_hit;
  logic [95:0] layer_rgb;
  logic [3:0]  blink_mask;
  logic [9:0]  DrawX, DrawY;
  logic        blank_n;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        blank_n_out;

  typedef struct {
    logic [23:0] rgb;
    logic        bl;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic        issue = 1'b0;
  logic [1:0]  vpipe = 2'b00;
  int          checks = 0;
  int          errors = 0;
  int          fcount = 0;
  logic        end_chk = 1'b0;
  logic        end_done = 1'b0;
  logic [23:0] ex;
  logic        do_chk;
  logic [3:0]  st;

  layered_color_mapper dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_start (frame_start),
    .status      (status),
    .layer_hit   (layer_hit),
    .layer_rgb   (layer_rgb),
    .blink_mask  (blink_mask),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank_n     (blank_n),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B),
    .blank_n_out (blank_n_out)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) vpipe <= {vpipe[0], issue};

  always @(negedge Clk) begin
    if (vpipe[1]) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got %h/%h/%h blank %b, no expected entry",
                 VGA_R, VGA_G, VGA_B, blank_n_out);
      end else begin
        mon_e = sb.pop_front();
        if ({VGA_R, VGA_G, VGA_B, blank_n_out} !== {mon_e.rgb, mon_e.bl}) begin
          errors++;
          $display("FAIL %s: got %h/%h/%h blank %b, expected %h/%h/%h blank %b",
                   mon_e.name, VGA_R, VGA_G, VGA_B, blank_n_out,
                   mon_e.rgb[23:16], mon_e.rgb[15:8], mon_e.rgb[7:0], mon_e.bl);
        end
      end
    end
    if (end_chk && !end_done) begin
      end_done = 1'b1;
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
      end
    end
  end

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk); #1;
      issue = 1'b0; frame_start = 1'b0; blank_n = 1'b0; layer_hit = 4'b1111;
    end
  endtask

  task automatic pix(input logic [3:0] hit, input logic [3:0] mask, input logic [9:0] x,
                     input logic bl, input logic [23:0] exp_rgb, input logic exp_bl,
                     input string nm);
    exp_t e;
    @(posedge Clk); #1;
    frame_start = 1'b0; layer_hit = hit; blink_mask = mask; DrawX = x;
    blank_n = bl; issue = 1'b1;
    e.rgb = exp_rgb; e.bl = exp_bl; e.name = nm;
    sb.push_back(e);
    @(posedge Clk); #1;
    issue = 1'b0; blank_n = 1'b0; layer_hit = 4'b1111; blink_mask = 4'b0000; DrawX = 10'd0;
  endtask

  task automatic frame(input logic [3:0] s);
    @(posedge Clk); #1;
    issue = 1'b0; blank_n = 1'b0; status = s; frame_start = 1'b1;
    fcount++;
    @(posedge Clk); #1;
    frame_start = 1'b0;
  endtask

  initial begin
    Reset_n = 1'b0; frame_start = 1'b0; status = ST_WAITING; layer_hit = 4'b0000;
    blink_mask = 4'b0000; DrawX = 10'd0; DrawY = 10'd100; blank_n = 1'b0;
    layer_rgb = {24'h0A0B0C, 24'h404040, 24'hFFFF00, 24'h123456};
    idle_cycles(3);
    Reset_n = 1'b1;

    // Waiting background, blanking, then a mid-frame reset
    pix(4'b0001, 4'b0000, 10'd80, 1'b1, 24'h000080, 1'b1, "wait_bg");
    frame(ST_WAITING);
    frame(ST_WAITING);
    pix(4'b0001, 4'b0000, 10'd80, 1'b0, 24'h000000, 1'b0, "wait_blank");
    @(posedge Clk); #1;
    Reset_n = 1'b0; blank_n = 1'b1; layer_hit = 4'b0000; issue = 1'b1;
    sb.push_back('{24'h000000, 1'b0, "reset_c1"});
    @(posedge Clk); #1;
    sb.push_back('{24'h000000, 1'b0, "reset_c2"});
    @(posedge Clk); #1;
    Reset_n = 1'b1; issue = 1'b0; blank_n = 1'b0;
    fcount = 0;
    pix(4'b0000, 4'b0000, 10'd80, 1'b1, 24'h000080, 1'b1, "after_reset");

    // Waiting -> playing fade
    frame(ST_PLAYING);
    pix(4'b0000, 4'b0000, 10'd80, 1'b1, 24'h000080, 1'b1, "fade_first_frame");
    frame(ST_PLAYING);
    pix(4'b0000, 4'b0000, 10'd80, 1'b1, 24'h000078, 1'b1, "fade_lvl15");
    for (int i = 0; i < 7; i++) frame(ST_PLAYING);
    pix(4'b0000, 4'b0000, 10'd80, 1'b1, 24'h000040, 1'b1, "fade_lvl8");
    for (int i = 0; i < 8; i++) frame(ST_PLAYING);
    pix(4'b0000, 4'b0000, 10'd80, 1'b1, 24'h000000, 1'b1, "fade_black");
    for (int i = 0; i < 16; i++) frame(ST_PLAYING);

    // Playing priority mux and gradient
    pix(4'b0110, 4'b0000, 10'd80,   1'b1, 24'hFFFF00, 1'b1, "prio_l1_over_l2");
    pix(4'b1001, 4'b0000, 10'd80,   1'b1, 24'h123456, 1'b1, "prio_l0_over_l3");
    pix(4'b1000, 4'b0000, 10'd80,   1'b1, 24'h0A0B0C, 1'b1, "only_l3");
    pix(4'b0000, 4'b0000, 10'd80,   1'b1, 24'h4F4F75, 1'b1, "grad_x80");
    pix(4'b0000, 4'b0000, 10'd0,    1'b1, 24'h4F4F7F, 1'b1, "grad_x0");
    pix(4'b0000, 4'b0000, 10'd1016, 1'b1, 24'h4F4F00, 1'b1, "grad_x1016");
    pix(4'b0010, 4'b0000, 10'd80,   1'b0, 24'h000000, 1'b0, "play_blank");

    // Blinking layer 0 over a 32-frame period
    while (fcount % 32 != 0) frame(ST_PLAYING);
    for (int k = 0; k <= 32; k++) begin
      ex = (k >= 16 && k < 32) ? 24'h4F4F75 : 24'h123456;
      pix(4'b0001, 4'b0001, 10'd80, 1'b1, ex, 1'b1, $sformatf("blink_k%0d", k));
      if (k == 0) pix(4'b0011, 4'b0001, 10'd80, 1'b1, 24'h123456, 1'b1, "blink_on_l0");
      if (k == 20) pix(4'b0011, 4'b0001, 10'd80, 1'b1, 24'hFFFF00, 1'b1, "blink_off_l1");
      frame(ST_PLAYING);
    end

    // Playing -> lose full swap
    frame(ST_LOSE);
    for (int k = 0; k <= 33; k++) begin
      if (k != 0) frame(ST_LOSE);
      do_chk = 1'b1;
      case (k)
        0:  ex = 24'h4F4F75;
        1:  ex = 24'h4A4A6D;
        8:  ex = 24'h27273A;
        15: ex = 24'h040407;
        16: ex = 24'h000000;
        17: ex = 24'h000800;
        24: ex = 24'h004000;
        32: ex = 24'h008000;
        33: ex = 24'h008000;
        default: begin ex = 24'h000000; do_chk = 1'b0; end
      endcase
      if (do_chk) pix(4'b0000, 4'b0000, 10'd80, 1'b1, ex, 1'b1, $sformatf("lose_k%0d", k));
    end

    // Return during fade-out, then redirect during fade-in
    frame(ST_PLAYING);
    for (int k = 0; k <= 37; k++) begin
      st = (k <= 11) ? ST_PLAYING : ((k <= 13) ? ST_LOSE : ST_WIN);
      if (k != 0) frame(st);
      do_chk = 1'b1;
      case (k)
        0:  ex = 24'h008000;
        1:  ex = 24'h007800;
        11: ex = 24'h002800;
        12: ex = 24'h002800;
        13: ex = 24'h003000;
        14: ex = 24'h003000;
        15: ex = 24'h002800;
        19: ex = 24'h000800;
        20: ex = 24'h000000;
        21: ex = 24'h080000;
        28: ex = 24'h400000;
        36: ex = 24'h800000;
        37: ex = 24'h800000;
        default: begin ex = 24'h000000; do_chk = 1'b0; end
      endcase
      if (do_chk) pix(4'b0000, 4'b0000, 10'd80, 1'b1, ex, 1'b1, $sformatf("redir_k%0d", k));
    end

    // Target changes mid fade-out to a non one-hot status
    frame(ST_WAITING);
    for (int k = 0; k <= 33; k++) begin
      st = (k <= 3) ? ST_WAITING : 4'b0011;
      if (k != 0) frame(st);
      do_chk = 1'b1;
      case (k)
        0:  ex = 24'h800000;
        2:  ex = 24'h700000;
        4:  ex = 24'h600000;
        16: ex = 24'h000000;
        20: ex = 24'h000000;
        32: ex = 24'h000000;
        33: ex = 24'h000000;
        default: begin ex = 24'h000000; do_chk = 1'b0; end
      endcase
      if (do_chk) pix(4'b0001, 4'b0000, 10'd80, 1'b1, ex, 1'b1, $sformatf("bad_k%0d", k));
    end
    pix(4'b0001, 4'b0000, 10'd80, 1'b0, 24'h000000, 1'b0, "bad_blank");

    idle_cycles(4);
    end_chk = 1'b1;
    idle_cycles(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
